// File: rtl/autotank_patrol.sv
// Autonomous enemy-tank patrol controller: walks a fixed route of dwell steps
// and emits the player-tank command word (one-hot direction + fire).
module autotank_patrol #(
    parameter int unsigned DWELL_CNT = 200000000,
    parameter int unsigned CNT_W     = 28,
    parameter int unsigned NUM_STEPS = 10,
    parameter logic [31:0] ROUTE     = 32'h0,
    parameter logic [15:0] FIRE_MASK = 16'h0,
    parameter bit          LOOP      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       pause,
    input  logic       blocked,
    output logic [4:0] player,
    output logic [3:0] step_idx,
    output logic       step_done,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, MOVE, FIRE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DWELL_CNT - 1);
    localparam logic [3:0]       LAST_STEP = 4'(NUM_STEPS - 1);

    state_t           state_q, state_d;
    logic [3:0]       step_q, step_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       player_q, player_d;
    logic             step_done_q, step_done_d;
    logic             done_q, done_d;
    logic             adv;

    function automatic logic [3:0] dir_of(input logic [3:0] s);
        return 4'b0001 << ROUTE[{s, 1'b0} +: 2];
    endfunction

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cnt_d       = cnt_q;
        player_d    = player_q;
        step_done_d = 1'b0;
        done_d      = 1'b0;
        adv         = 1'b0;
        if (!en) begin
            state_d  = IDLE;
            step_d   = 4'd0;
            cnt_d    = '0;
            player_d = 5'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = MOVE;
                    step_d   = 4'd0;
                    cnt_d    = '0;
                    player_d = {1'b0, dir_of(4'd0)};
                end
                MOVE: begin
                    // pause freezes everything, including a pending collision
                    if (!pause) begin
                        if (cnt_q == CNT_LAST || blocked) begin
                            step_done_d = 1'b1;
                            cnt_d       = '0;
                            if (FIRE_MASK[step_q]) begin
                                state_d  = FIRE;
                                player_d = {1'b1, dir_of(step_q)};
                            end else begin
                                adv = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                FIRE: adv = 1'b1;
                DONE: begin
                    player_d = 5'b0;
                    done_d   = 1'b1;
                end
                default: state_d = IDLE;
            endcase
            if (adv) begin
                if (step_q < LAST_STEP) begin
                    state_d  = MOVE;
                    step_d   = step_q + 4'd1;
                    player_d = {1'b0, dir_of(step_q + 4'd1)};
                end else if (LOOP) begin
                    state_d  = MOVE;
                    step_d   = 4'd0;
                    player_d = {1'b0, dir_of(4'd0)};
                end else begin
                    state_d  = DONE;
                    player_d = 5'b0;
                    done_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= 4'd0;
            cnt_q       <= '0;
            player_q    <= 5'b0;
            step_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            player_q    <= player_d;
            step_done_q <= step_done_d;
            done_q      <= done_d;
        end
    end

    assign player    = player_q;
    assign step_idx  = step_q;
    assign step_done = step_done_q;
    assign done      = done_q;

endmodule

// File: doc/autotank_patrol.md
Name: autotank_patrol

Overview:
Parametrised autonomous enemy-tank controller. Walks a programmable patrol route of up to 16 steps, dwelling a fixed number of cycles per step. Emits the same 5-bit player command word the player-tank datapath consumes: one-hot direction in [3:0], fire in [4]. Over the fixed-route green-tank driver, it adds:
- per-step fire mask
- early step exit on collision (blocked)
- pause and enable
- loop or one-shot mode
- step-index and step-done status

Parameters:
DWELL_CNT, 200000000, cycles spent on each step; legal range 1 to 2^CNT_W-1.
CNT_W, 28, dwell counter width.
NUM_STEPS, 10, route length; legal range 1-16.
ROUTE, 32'h0, packed 2-bit direction per step; step i at bits [2i+1:2i]; 00=DOWN, 01=RIGHT, 10=UP, 11=LEFT.
FIRE_MASK, 16'h0, bit i=1 means a fire pulse at the end of step i.
LOOP, 1, 1: wrap to step 0 after last step; 0: stop in DONE.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
en  input  1  run enable
pause  input  1  freeze dwell counter and outputs
blocked  input  1  collision from map logic; ends current step early
player  output  5  [4]=fire, [3]=LEFT, [2]=UP, [1]=RIGHT, [0]=DOWN
step_idx  output  4  current route step
step_done  output  1  one-cycle pulse per completed step
done  output  1  high in DONE state (LOOP=0 only)

Behaviour:
- One clock, clk. Reset is asynchronous and active-high.
- Reset values: state=IDLE, player=5'b0, step_idx=0, dwell counter=0, step_done=0, done=0.
- All outputs are registered.
- Direction decode: player[3:0] = 4'b0001 << ROUTE[2*step_idx +: 2].
- States: IDLE, MOVE, FIRE, DONE.
- IDLE:
  - player=0.
  - en=1 -> MOVE at next edge, with step_idx=0 and count=0.
  - player shows the step-0 direction from the first MOVE cycle (1-cycle latency from en).
- MOVE:
  - player[3:0]=decoded direction, player[4]=0.
  - If pause=0, count increments each cycle.
  - Step end occurs when (count==DWELL_CNT-1 or blocked=1) and pause=0.
  - At step end: step_done<=1 for exactly one cycle and count<=0.
  - If FIRE_MASK[step_idx]=1 -> FIRE; otherwise advance the step.
- FIRE:
  - Lasts exactly one cycle (pause ignored).
  - player[4]=1, direction bits hold the current step's direction.
  - Then advance the step.
- Advance the step:
  - If step_idx < NUM_STEPS-1: step_idx+1, go to MOVE.
  - Else if LOOP=1: step_idx=0, go to MOVE.
  - Else: go to DONE.
- DONE:
  - player=0, done=1, step_idx holds NUM_STEPS-1.
  - Exit only via en=0 (-> IDLE) or reset.
- en=0 in any state:
  - IDLE at next edge, player=0, count=0, step_idx=0, done=0, step_done=0.
  - en has priority over everything except reset.
- pause=1 in MOVE:
  - count, step_idx and player frozen; blocked ignored.
  - pause beats blocked.
- blocked and terminal count in the same cycle produce a single step end (one step_done, one advance).
- blocked held high across steps: each MOVE step lasts 1 cycle.
- Step duration without blocked or pause:
  - Exactly DWELL_CNT cycles of MOVE.
  - Plus 1 FIRE cycle if masked.
- DWELL_CNT=1: every step lasts one cycle.
- Reset asserted mid-step: all outputs clear immediately (asynchronous). On release, the block starts in IDLE.

Test Plan:
- DWELL_CNT=4, NUM_STEPS=3, ROUTE=6'b11_10_00 (DOWN, UP, LEFT), LOOP=1, FIRE_MASK=0; raise en -> player shows 00001 for 4 cycles, then 00100 for 4, then 01000 for 4, then 00001 again; step_done pulses every 4 cycles; step_idx goes 0,1,2,0.
- Same setup with FIRE_MASK=3'b010 -> after 4 UP cycles, one cycle with player=10100, then LEFT; step 1 lasts 5 cycles total.
- Pulse blocked for 1 cycle at count=1 of step 0 -> step 0 ends after 2 cycles with one step_done; step 1 gets a full 4 cycles.
- Hold pause for 3 cycles mid-step; assert blocked during pause -> player and step_idx frozen, no step_done; step completes exactly 3 cycles late.
- LOOP=0, NUM_STEPS=2 -> after 8 cycles done=1, player=0, step_idx=1; drop en -> IDLE, done=0; re-raise en -> restarts at step 0.
- Assert reset asynchronously between clock edges mid-step -> player=0 and step_idx=0 before the next edge; deassert with en=1 -> MOVE step 0 one cycle later.
